// File: rtl/key_filter_array_if.sv
// Key filter bus: raw key levels in, debounced levels and event pulses out.
interface key_filter_array_if #(parameter int N = 4);
    logic [N-1:0] key;
    logic [N-1:0] key_state;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] hold_pulse;
    logic         any_pressed;

    modport master (output key,
                    input  key_state, press_pulse, release_pulse, hold_pulse, any_pressed);
    modport slave  (input  key,
                    output key_state, press_pulse, release_pulse, hold_pulse, any_pressed);
endinterface

// File: rtl/key_filter_array.sv
// N-channel key debouncer with press/release/long-press/auto-repeat pulses.
// Each channel is an independent key_filter_lane instance.
module key_filter_lane #(
    parameter int STABLE_CYCLES = 240000,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2400000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);
    localparam int SW   = $clog2(STABLE_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] R_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic          sync1, sync2;
    logic          pressed, accept;
    logic [SW-1:0] scnt;
    logic [HW-1:0] hcnt;
    logic          held;   // first long-press pulse already issued for this press

    always_comb begin
        pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
        accept  = (pressed != key_state) && (scnt == S_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= IDLE_LVL;
            sync2         <= IDLE_LVL;
            key_state     <= 1'b0;
            scnt          <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            hcnt          <= '0;
            held          <= 1'b0;
        end else begin
            sync1         <= key;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;

            if (pressed == key_state) begin
                scnt <= '0;
            end else if (accept) begin
                key_state     <= pressed;
                scnt          <= '0;
                press_pulse   <= pressed;
                release_pulse <= ~pressed;
            end else begin
                scnt <= scnt + 1'b1;
            end

            // Counter resets at each target, so it never exceeds HMAX and cannot wrap;
            // a release edge (accept while pressed) suppresses any hold pulse.
            if (!key_state || accept) begin
                hcnt <= '0;
                held <= 1'b0;
            end else if (!held) begin
                if (hcnt == H_LAST) begin
                    hold_pulse <= 1'b1;
                    held       <= 1'b1;
                    hcnt       <= '0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end else if (REPEAT_CYCLES > 0) begin
                if (hcnt == R_LAST) begin
                    hold_pulse <= 1'b1;
                    hcnt       <= '0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end
endmodule

module key_filter_array #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 240000,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_CYCLES   = 12000000,
    parameter int REPEAT_CYCLES = 2400000
) (
    input  logic               clk,
    input  logic               rst,
    key_filter_array_if.slave  bus
);
    logic [N-1:0] ks, pp, rp, hp;

    for (genvar i = 0; i < N; i++) begin : g_lane
        key_filter_lane #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .key           (bus.key[i]),
            .key_state     (ks[i]),
            .press_pulse   (pp[i]),
            .release_pulse (rp[i]),
            .hold_pulse    (hp[i])
        );
    end

    assign bus.key_state     = ks;
    assign bus.press_pulse   = pp;
    assign bus.release_pulse = rp;
    assign bus.hold_pulse    = hp;
    assign bus.any_pressed   = |ks;
endmodule

// File: tb/tb_key_filter_array.sv
// Directed bench: two instances (auto-repeat on / off) driven by the same keys.
module tb_key_filter_array;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_drv = 2'b11;

    key_filter_array_if #(.N(2)) a ();
    key_filter_array_if #(.N(2)) b ();
    assign a.key = key_drv;
    assign b.key = key_drv;

    key_filter_array #(.N(2), .STABLE_CYCLES(4), .ACTIVE_LOW(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(3))
        u_dut_a (.clk(clk), .rst(rst), .bus(a));
    key_filter_array #(.N(2), .STABLE_CYCLES(4), .ACTIVE_LOW(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(0))
        u_dut_b (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;
    int excl;
    logic [63:0] p0, r0, h0, hb0, ks0, act1, pb, anyl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0; excl = 0;
        p0 = '0; r0 = '0; h0 = '0; hb0 = '0; ks0 = '0; act1 = '0; pb = '0; anyl = '0;
    endtask

    // Step n cycles, recording per-cycle outputs at bit index = cycle number.
    task automatic step_log(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (a.press_pulse[0])      p0[cyc]   = 1'b1;
            if (a.release_pulse[0])    r0[cyc]   = 1'b1;
            if (a.hold_pulse[0])       h0[cyc]   = 1'b1;
            if (b.hold_pulse[0])       hb0[cyc]  = 1'b1;
            if (a.key_state[0])        ks0[cyc]  = 1'b1;
            if (a.press_pulse == 2'b11) pb[cyc]  = 1'b1;
            if (a.any_pressed)         anyl[cyc] = 1'b1;
            if (a.key_state[1] | a.press_pulse[1] | a.release_pulse[1] | a.hold_pulse[1])
                act1[cyc] = 1'b1;
            for (int c = 0; c < 2; c++) begin
                if ($countones({a.press_pulse[c], a.release_pulse[c], a.hold_pulse[c]}) > 1) excl++;
                if ($countones({b.press_pulse[c], b.release_pulse[c], b.hold_pulse[c]}) > 1) excl++;
            end
        end
    endtask

    function automatic logic [63:0] range(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] outs_all();
        return {40'd0, a.key_state, a.press_pulse, a.release_pulse, a.hold_pulse, a.any_pressed,
                b.key_state, b.press_pulse, b.release_pulse, b.hold_pulse, b.any_pressed, 2'b00};
    endfunction

    initial begin
        // Reset with keys released
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs_all(), 64'd0);
        rst = 1'b0;
        clear_log();
        step_log(4);
        chk("idle_after_reset", p0 | r0 | h0 | ks0 | act1 | anyl, 64'd0);

        // Clean press of key 0, then clean release
        clear_log();
        key_drv = 2'b10;
        step_log(8);
        key_drv = 2'b11;
        step_log(8);
        chk("press_edge6", p0, 64'd1 << 6);
        chk("key_state0", ks0, range(6, 13));
        chk("release_edge14", r0, 64'd1 << 14);
        chk("no_hold_short", h0 | hb0, 64'd0);
        chk("ch1_quiet", act1, 64'd0);

        // Bounce, then steady press held long, then release
        clear_log();
        for (int k = 0; k < 10; k++) begin
            key_drv = (k % 2 == 0) ? 2'b10 : 2'b11;
            step_log(2);
        end
        key_drv = 2'b10;
        step_log(26);
        key_drv = 2'b11;
        step_log(12);
        chk("bounce_press_once", p0, 64'd1 << 26);
        chk("hold_repeat", h0, (64'd1 << 36) | (64'd1 << 39) | (64'd1 << 42) |
                               (64'd1 << 45) | (64'd1 << 48) | (64'd1 << 51));
        chk("hold_norepeat", hb0, 64'd1 << 36);
        chk("release_after_hold", r0, 64'd1 << 52);
        chk("ch1_quiet2", act1, 64'd0);
        chk("exclusive_pulses", 64'(excl), 64'd0);

        // Both keys together, staggered release
        clear_log();
        key_drv = 2'b00;
        step_log(8);
        key_drv = 2'b01;
        step_log(4);
        key_drv = 2'b11;
        step_log(10);
        chk("both_press", pb, 64'd1 << 6);
        chk("any_pressed", anyl, range(6, 17));
        chk("release0_stagger", r0, 64'd1 << 14);
        chk("exclusive_pulses2", 64'(excl), 64'd0);

        // Reset in the middle of a press count, key held through reset
        step_log(4);
        key_drv = 2'b10;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 chk("mid_reset_out_a", outs_all(), 64'd0);
        @(posedge clk); #1 chk("mid_reset_out_b", outs_all(), 64'd0);
        rst = 1'b0;
        clear_log();
        step_log(8);
        chk("press_after_reset", p0, 64'd1 << 6);
        chk("ks_after_reset", ks0, range(6, 8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/key_filter_array.md
KEY_FILTER_ARRAY -- requirements
Module: key_filter_array

Interface
REQ-001 Parameter N, default 4: number of independent key channels, 1..32.
REQ-002 Parameter STABLE_CYCLES, default 240000: cycles a synchronised input must differ from the debounced state before acceptance, 20 ms at 12 MHz, minimum 1.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.
REQ-004 Parameter HOLD_CYCLES, default 12000000: cycles of continuous debounced press before the first hold_pulse, 1 s at 12 MHz, minimum 1.
REQ-005 Parameter REPEAT_CYCLES, default 2400000: cycles between subsequent hold_pulses while still pressed; 0 disables repeat.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 key  input  N  raw asynchronous key levels, polarity per ACTIVE_LOW.
REQ-009 key_state  output  N  debounced level per channel, 1 = pressed, independent of ACTIVE_LOW.
REQ-010 press_pulse  output  N  one-cycle high on accepted release-to-press transition.
REQ-011 release_pulse  output  N  one-cycle high on accepted press-to-release transition.
REQ-012 hold_pulse  output  N  one-cycle high on long-press and on each auto-repeat.
REQ-013 any_pressed  output  1  OR-reduction of key_state.

Function
REQ-014 Each channel SHALL pass key through a two-flop synchroniser, then normalise to pressed = 1; no combinational path from key to any output.
REQ-015 Each channel SHALL own a stability counter sized ceil(log2(STABLE_CYCLES+1)) bits; all channels operate independently and concurrently.
REQ-016 Normalised synchronised value equal to key_state: stability counter SHALL clear to 0.
REQ-017 Value differs and counter < STABLE_CYCLES-1: counter SHALL increment by 1.
REQ-018 Value differs and counter == STABLE_CYCLES-1: key_state SHALL take the new value and the counter SHALL clear on that edge.
REQ-019 Latency: a clean key change first sampled on edge 1 SHALL update key_state on edge STABLE_CYCLES+2; any bounce back before then restarts the full count.
REQ-020 press_pulse/release_pulse SHALL be registered and high for exactly the one cycle in which key_state has just changed, and low otherwise.
REQ-021 Each channel SHALL own a hold counter; it SHALL clear while key_state = 0 and on the press transition, and count while key_state = 1.
REQ-022 hold_pulse SHALL assert HOLD_CYCLES cycles after the press_pulse cycle; with REPEAT_CYCLES > 0 it SHALL reassert every REPEAT_CYCLES cycles while pressed; with 0 it fires once per press.
REQ-023 Release SHALL stop hold/repeat immediately; no hold_pulse in or after the release_pulse cycle.
REQ-024 Hold and repeat counters SHALL saturate, never wrap, so a press held arbitrarily long produces no spurious pulse.
REQ-025 press_pulse, release_pulse and hold_pulse of one channel SHALL never be high in the same cycle; on coincidence the release takes priority.

Reset
REQ-026 While rst = 1 at a clock edge: synchroniser flops SHALL load the released raw level; key_state, all pulses, any_pressed and all counters SHALL be 0.
REQ-027 Reset mid-bounce or mid-hold SHALL discard all progress; a key already held through reset SHALL produce press_pulse only after full filtering, STABLE_CYCLES+2 edges after rst falls.
REQ-028 No output pulse SHALL be generated in the cycle rst deasserts.

Verification (N=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1)
REQ-029 key[0] 1->0, held clean -> key_state[0]=1 and press_pulse[0]=1 one cycle, on edge 6; key[1] untouched, all channel-1 outputs 0.
REQ-030 key[0] toggles 0/1 every 2 cycles for 20 cycles, then steady 0 -> no pulses during bounce; press_pulse[0] exactly once, 6 edges after last toggle.
REQ-031 key[0] held pressed 20 cycles after press_pulse -> hold_pulse[0] at +10, +13, +16, +19; then release -> release_pulse[0] once, no further hold_pulse.
REQ-032 Both keys pressed same cycle -> press_pulse=2'b11 same cycle; any_pressed=1 until both released.
REQ-033 rst asserted 3 cycles into a press count, key held through reset -> outputs 0 during reset; press_pulse[0] 6 edges after rst falls.
REQ-034 Re-run REQ-031 with REPEAT_CYCLES=0 -> single hold_pulse[0] at +10 only.
